rvh_pmp_check_requester: RTL and testbench

- Initiator side of the PMP permission-check interface; it drives the broadcast check request to all rvh PMP entries and resolves their per-entry match/fail answers.
- Accepts physical-address access requests from the MMU/LSU over a valid/ready handshake.
- Applies RISC-V priority and M-mode rules, and returns one registered response per request.
- Sits between the PTW/LSU request path and the PMP entry array.

---
 rtl/rvh_pmp_pkg.sv | 23 ++
 rtl/rvh_pmp_prio_enc.sv | 20 ++
 rtl/rvh_pmp_check_requester.sv | 127 ++++++++++++
 tb/tb_rvh_pmp_check_requester.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_pmp_pkg.sv
// Shared constants and types for the PMP check requester and its helpers.
package rvh_pmp_pkg;

    localparam logic [1:0] PMP_ACCESS_TYPE_R = 2'd0;
    localparam logic [1:0] PMP_ACCESS_TYPE_W = 2'd1;
    localparam logic [1:0] PMP_ACCESS_TYPE_X = 2'd2;

    typedef enum logic [1:0] {
        PMPCFG_A_OFF   = 2'd0,
        PMPCFG_A_TOR   = 2'd1,
        PMPCFG_A_NA4   = 2'd2,
        PMPCFG_A_NAPOT = 2'd3
    } pmpcfg_a_e;

    localparam int unsigned PMPCFG_L_BIT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } pmp_req_state_e;

endpackage

// File: rtl/rvh_pmp_prio_enc.sv
// Lowest-index priority encoder over the per-entry match vector.
module rvh_pmp_prio_enc #(
    parameter int NUM_ENTRY = 16,
    parameter int IDX_WIDTH = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
    input  logic [NUM_ENTRY-1:0] req,
    output logic                 hit,
    output logic [IDX_WIDTH-1:0] idx
);

    always_comb begin
        hit = |req;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int unsigned i = NUM_ENTRY; i > 0; i--) begin
            if (req[i-1]) idx = IDX_WIDTH'(i - 1);
        end
    end

endmodule

// File: rtl/rvh_pmp_check_requester.sv
// Drives the broadcast PMP permission check and resolves entry answers into
// one registered response per accepted request.
module rvh_pmp_check_requester
    import rvh_pmp_pkg::*;
#(
    parameter int PADDR_WIDTH = 56,
    parameter int NUM_ENTRY   = 16,
    parameter int ID_WIDTH    = 4,
    parameter int IDX_WIDTH   = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_vld_i,
    output logic                   req_rdy_o,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [1:0]             req_access_type_i,
    input  logic                   req_priv_m_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic                   permission_check_vld_o,
    output logic [PADDR_WIDTH-1:0] permission_check_paddr_o,
    output logic [1:0]             permission_check_access_type_o,
    input  logic [NUM_ENTRY-1:0]   entry_match_i,
    input  logic [NUM_ENTRY-1:0]   entry_fail_i,
    input  logic [NUM_ENTRY-1:0]   entry_lock_i,
    input  logic                   pmp_cfg_change_i,
    output logic                   resp_vld_o,
    input  logic                   resp_rdy_i,
    output logic                   resp_fault_o,
    output logic                   resp_hit_o,
    output logic [IDX_WIDTH-1:0]   resp_entry_idx_o,
    output logic [ID_WIDTH-1:0]    resp_id_o
);

    pmp_req_state_e state, state_nxt;

    logic [PADDR_WIDTH-1:0] paddr_q;
    logic [1:0]             type_q;
    logic                   priv_m_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic                   fault_q;
    logic                   hit_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [ID_WIDTH-1:0]    resp_id_q;

    logic                 req_hsk;
    logic                 commit;
    logic                 win_hit;
    logic [IDX_WIDTH-1:0] win_idx;
    logic                 win_fault;

    rvh_pmp_prio_enc #(
        .NUM_ENTRY (NUM_ENTRY),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_prio_enc (
        .req (entry_match_i),
        .hit (win_hit),
        .idx (win_idx)
    );

    always_comb begin
        win_fault = 1'b0;
        if (type_q == 2'd3) begin
            win_fault = 1'b1;
        end else if (win_hit) begin
            // M-mode bypasses a failing entry unless that entry is locked.
            win_fault = entry_fail_i[win_idx] & (~priv_m_q | entry_lock_i[win_idx]);
        end else begin
            win_fault = ~priv_m_q;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy_o = (state == IDLE) | ((state == RESP) & resp_rdy_i);
        req_hsk   = req_vld_i & req_rdy_o;
        commit    = 1'b0;
        unique case (state)
            IDLE: if (req_hsk) state_nxt = CHECK;
            CHECK: begin
                if (!pmp_cfg_change_i) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (resp_rdy_i) state_nxt = req_hsk ? CHECK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            paddr_q   <= '0;
            type_q    <= '0;
            priv_m_q  <= 1'b0;
            id_q      <= '0;
            fault_q   <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            resp_id_q <= '0;
        end else begin
            state <= state_nxt;
            if (req_hsk) begin
                paddr_q  <= req_paddr_i;
                type_q   <= req_access_type_i;
                priv_m_q <= req_priv_m_i;
                id_q     <= req_id_i;
            end
            if (commit) begin
                fault_q   <= win_fault;
                hit_q     <= win_hit;
                idx_q     <= win_idx;
                resp_id_q <= id_q;
            end
        end
    end

    assign permission_check_vld_o         = (state == CHECK);
    assign permission_check_paddr_o       = paddr_q;
    assign permission_check_access_type_o = type_q;
    assign resp_vld_o                     = (state == RESP);
    assign resp_fault_o                   = fault_q;
    assign resp_hit_o                     = hit_q;
    assign resp_entry_idx_o               = idx_q;
    assign resp_id_o                      = resp_id_q;

endmodule

// File: tb/tb_rvh_pmp_check_requester.sv
// Directed bench for rvh_pmp_check_requester: vector table plus recheck,
// backpressure and mid-check reset sequences.
module tb_rvh_pmp_check_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld_i = 1'b0;
    logic        req_rdy_o;
    logic [55:0] req_paddr_i = '0;
    logic [1:0]  req_access_type_i = '0;
    logic        req_priv_m_i = 1'b0;
    logic [3:0]  req_id_i = '0;
    logic        permission_check_vld_o;
    logic [55:0] permission_check_paddr_o;
    logic [1:0]  permission_check_access_type_o;
    logic [15:0] entry_match_i = '0;
    logic [15:0] entry_fail_i = '0;
    logic [15:0] entry_lock_i = '0;
    logic        pmp_cfg_change_i = 1'b0;
    logic        resp_vld_o;
    logic        resp_rdy_i = 1'b1;
    logic        resp_fault_o;
    logic        resp_hit_o;
    logic [3:0]  resp_entry_idx_o;
    logic [3:0]  resp_id_o;

    int n_checks = 0;
    int n_errors = 0;

    rvh_pmp_check_requester #(
        .PADDR_WIDTH (56),
        .NUM_ENTRY   (16),
        .ID_WIDTH    (4)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .req_vld_i                      (req_vld_i),
        .req_rdy_o                      (req_rdy_o),
        .req_paddr_i                    (req_paddr_i),
        .req_access_type_i              (req_access_type_i),
        .req_priv_m_i                   (req_priv_m_i),
        .req_id_i                       (req_id_i),
        .permission_check_vld_o         (permission_check_vld_o),
        .permission_check_paddr_o       (permission_check_paddr_o),
        .permission_check_access_type_o (permission_check_access_type_o),
        .entry_match_i                  (entry_match_i),
        .entry_fail_i                   (entry_fail_i),
        .entry_lock_i                   (entry_lock_i),
        .pmp_cfg_change_i               (pmp_cfg_change_i),
        .resp_vld_o                     (resp_vld_o),
        .resp_rdy_i                     (resp_rdy_i),
        .resp_fault_o                   (resp_fault_o),
        .resp_hit_o                     (resp_hit_o),
        .resp_entry_idx_o               (resp_entry_idx_o),
        .resp_id_o                      (resp_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [55:0] paddr;
        logic [1:0]  atype;
        logic        priv_m;
        logic [3:0]  id;
        logic [15:0] match;
        logic [15:0] fail;
        logic [15:0] lock;
        logic        exp_fault;
        logic        exp_hit;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic [55:0] paddr, input logic [1:0] atype,
                             input logic priv_m, input logic [3:0] id);
        req_vld_i         = 1'b1;
        req_paddr_i       = paddr;
        req_access_type_i = atype;
        req_priv_m_i      = priv_m;
        req_id_i          = id;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        drive_req(v.paddr, v.atype, v.priv_m, v.id);
        entry_match_i = v.match;
        entry_fail_i  = v.fail;
        entry_lock_i  = v.lock;
        @(posedge clk); #1;
        req_vld_i = 1'b0;
        @(negedge clk);
        check("check_vld", 64'(permission_check_vld_o), 64'd1);
        check("check_paddr", 64'(permission_check_paddr_o), 64'(v.paddr));
        check("check_type", 64'(permission_check_access_type_o), 64'(v.atype));
        @(posedge clk);
        @(negedge clk);
        check("resp_vld", 64'(resp_vld_o), 64'd1);
        check("resp_fault", 64'(resp_fault_o), 64'(v.exp_fault));
        check("resp_hit", 64'(resp_hit_o), 64'(v.exp_hit));
        check("resp_idx", 64'(resp_entry_idx_o), 64'(v.exp_idx));
        check("resp_id", 64'(resp_id_o), 64'(v.id));
    endtask

    initial begin
        vecs[0] = '{56'h1000, 2'd0, 1'b0, 4'h1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[1] = '{56'h1000, 2'd0, 1'b1, 4'h2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{56'h2000, 2'd1, 1'b0, 4'h3, 16'h0028, 16'h0008, 16'h0000, 1'b1, 1'b1, 4'd3};
        vecs[3] = '{56'h2000, 2'd1, 1'b0, 4'h4, 16'h0028, 16'h0020, 16'h0000, 1'b0, 1'b1, 4'd3};
        vecs[4] = '{56'h3000, 2'd2, 1'b1, 4'h5, 16'h0004, 16'h0004, 16'h0000, 1'b0, 1'b1, 4'd2};
        vecs[5] = '{56'h3000, 2'd2, 1'b1, 4'h6, 16'h0004, 16'h0004, 16'h0004, 1'b1, 1'b1, 4'd2};
        vecs[6] = '{56'hFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 4'h7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[7] = '{56'h4000, 2'd3, 1'b1, 4'h8, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd15};
        vecs[8] = '{56'h5000, 2'd0, 1'b0, 4'h9, 16'h8001, 16'h8000, 16'h0000, 1'b0, 1'b1, 4'd0};
        vecs[9] = '{56'h6000, 2'd0, 1'b1, 4'hF, 16'h0080, 16'h0080, 16'h0080, 1'b1, 1'b1, 4'd7};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp_vld", 64'(resp_vld_o), 64'd0);
        check("rst_check_vld", 64'(permission_check_vld_o), 64'd0);
        check("rst_req_rdy", 64'(req_rdy_o), 64'd1);
        check("rst_fault", 64'(resp_fault_o), 64'd0);
        check("rst_id", 64'(resp_id_o), 64'd0);
        check("rst_paddr", 64'(permission_check_paddr_o), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Config changes for two cycles: only third-cycle entry answers count.
        @(posedge clk); #1;
        drive_req(56'h7000, 2'd0, 1'b0, 4'hA);
        @(posedge clk); #1;
        req_vld_i        = 1'b0;
        pmp_cfg_change_i = 1'b1;
        entry_match_i    = 16'h0001;
        entry_fail_i     = 16'h0001;
        entry_lock_i     = 16'h0000;
        @(negedge clk);
        check("rechk_vld_c1", 64'(permission_check_vld_o), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rechk_vld_c2", 64'(permission_check_vld_o), 64'd1);
        check("rechk_resp_c2", 64'(resp_vld_o), 64'd0);
        @(posedge clk); #1;
        pmp_cfg_change_i = 1'b0;
        entry_match_i    = 16'h0010;
        entry_fail_i     = 16'h0000;
        @(negedge clk);
        check("rechk_vld_c3", 64'(permission_check_vld_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("rechk_resp_vld", 64'(resp_vld_o), 64'd1);
        check("rechk_check_off", 64'(permission_check_vld_o), 64'd0);
        check("rechk_fault", 64'(resp_fault_o), 64'd0);
        check("rechk_hit", 64'(resp_hit_o), 64'd1);
        check("rechk_idx", 64'(resp_entry_idx_o), 64'd4);
        check("rechk_id", 64'(resp_id_o), 64'hA);

        // Response backpressure with a second request waiting.
        @(posedge clk); #1;
        resp_rdy_i = 1'b0;
        entry_match_i = 16'h0000;
        drive_req(56'h8000, 2'd0, 1'b0, 4'h5);
        @(posedge clk); #1;
        drive_req(56'h9000, 2'd1, 1'b1, 4'h6);
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_resp_vld", 64'(resp_vld_o), 64'd1);
            check("bp_req_rdy", 64'(req_rdy_o), 64'd0);
            check("bp_fault", 64'(resp_fault_o), 64'd1);
            check("bp_id", 64'(resp_id_o), 64'h5);
            check("bp_paddr", 64'(permission_check_paddr_o), 64'h8000);
            @(posedge clk);
        end
        #1 resp_rdy_i = 1'b1;
        @(negedge clk);
        check("bp_req_rdy_rel", 64'(req_rdy_o), 64'd1);
        @(posedge clk); #1;
        req_vld_i = 1'b0;
        @(negedge clk);
        check("b2b_check_vld", 64'(permission_check_vld_o), 64'd1);
        check("b2b_resp_vld", 64'(resp_vld_o), 64'd0);
        check("b2b_paddr", 64'(permission_check_paddr_o), 64'h9000);
        @(posedge clk);
        @(negedge clk);
        check("b2b_resp_vld2", 64'(resp_vld_o), 64'd1);
        check("b2b_fault", 64'(resp_fault_o), 64'd0);
        check("b2b_id", 64'(resp_id_o), 64'h6);

        // Reset while a check is in flight drops the request.
        @(posedge clk); #1;
        drive_req(56'hA000, 2'd0, 1'b0, 4'hC);
        @(posedge clk); #1;
        req_vld_i = 1'b0;
        @(negedge clk);
        check("rst_mid_in_check", 64'(permission_check_vld_o), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_check_vld", 64'(permission_check_vld_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_resp_vld", 64'(resp_vld_o), 64'd0);
            check("rst_mid_idle", 64'(req_rdy_o), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
